muldiv_sched: RTL and testbench
===============================

// Module: muldiv_sched
// PURPOSE
//  Sequencer/owner of the HI/LO register pair. The decoder's hilowrite class
//  (MULT, MULTU, DIV, DIVU, MTHI, MTLO) is issued here from EX. Runs a
//  32-iteration shift-add multiply or restoring divide, stalls the pipeline
//  while busy and commits HI/LO atomically. MFHI/MFLO read the hi/lo outputs.
// PARAMETERS
//  WIDTH   32  operand/HI/LO width; iteration count equals WIDTH
// PORTS
//  clk          in   1      rising-edge clock
//  resetn       in   1      asynchronous, active-low reset
//  start        in   1      issue op this cycle (EX valid and hilowrite)
//  op           in   3      000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; others ignored
//  src_a        in   WIDTH  rs value (multiplicand/dividend/MT data)
//  src_b        in   WIDTH  rt value (multiplier/divisor)
//  flush        in   1      exception/flush; cancels in-flight op
//  stall        out  1      combinational pipeline hold request
//  busy         out  1      registered: state != IDLE
//  done         out  1      1-cycle pulse: HI/LO committed by MUL/DIV
//  div_by_zero  out  1      1-cycle pulse together with done on DIV/DIVU by 0
//  hi, lo       out  WIDTH  architectural HI/LO registers
// BEHAVIOUR
//  Reset (async, resetn=0): state=IDLE, hi=lo=0, busy=done=div_by_zero=0.
//  FSM states: IDLE, RUN, FIX, ZDIV.
//   IDLE: start & MUL/DIV op & !flush -> latch |a|,|b| (signed ops take
//     magnitudes; unsigned use raw), sign flags, cnt=0 -> RUN.
//     DIV/DIVU with src_b==0 -> ZDIV instead.
//     start & MTHI/MTLO & !flush -> hi/lo <= src_a at that edge; stay IDLE.
//   RUN: one iteration per cycle, cnt++; after WIDTH iterations -> FIX.
//   FIX: sign correction, hi/lo written at the FIX->IDLE edge; done=1 next cycle.
//   ZDIV: -> IDLE; hi/lo unchanged; done=div_by_zero=1 next cycle.
//  stall = (state!=IDLE) | (start & op in {MULT,MULTU,DIV,DIVU} & !flush).
//   MUL/DIV: stall high WIDTH+2 cycles (34 at default) from start cycle;
//   pipeline reads hi/lo the cycle stall drops. Divide-by-zero: stall 2 cycles.
//  Arithmetic: MUL gives 2*WIDTH product {hi,lo}; negated if operand signs
//   differ (signed). DIV: lo=quotient, hi=remainder; quotient negated if signs
//   differ, remainder takes dividend sign. 0x80000000/-1 -> lo=0x80000000,
//   hi=0 (two's-complement wrap, no trap). MTHI/MTLO no stall, no done.
//  Boundaries:
//   flush in RUN/FIX/ZDIV -> IDLE at next edge; hi/lo unchanged; no done.
//   flush with start same cycle -> start ignored.
//   start while busy -> ignored (pipeline is stalled; must not occur).
//   resetn low mid-op -> immediate IDLE, hi=lo=0, in-flight result lost.
// CONFIGURATION
//  MULDIV_FAST_MUL_EN defined: MULT/MULTU computed by single-cycle 64-bit
//   multiply, IDLE -> FIX directly (skips RUN); stall 2 cycles, done on 3rd.
//   DIV path unchanged. Undefined: iterative multiply as above.
// TESTING
//  1 MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> stall 34 cycles, hi=0xFFFFFFFE,
//    lo=0x00000001, done 1 cycle.
//  2 MULT a=-3 b=5 -> hi=0xFFFFFFFF lo=0xFFFFFFF1; DIVU 7/2 -> lo=3 hi=1.
//  3 DIV a=-7 b=2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF; 0x80000000/-1 -> lo=0x80000000 hi=0.
//  4 DIV a=5 b=0 (hi=0x11,lo=0x22) -> stall 2 cycles, hi/lo unchanged,
//    done=div_by_zero=1 for one cycle.
//  5 MULT started, flush at RUN cycle 10 -> IDLE next cycle, busy=0,
//    hi/lo unchanged, no done; then MTHI 0x1234 -> hi=0x1234, stall never high.
//  6 resetn=0 mid-RUN -> busy=0, hi=lo=0 without clock edge; with
//    MULDIV_FAST_MUL_EN, MULTU 0xFFFFFFFF^2 -> stall exactly 2 cycles, same result.

Source files
------------

// File: rtl/muldiv_sched.sv
// muldiv_sched: owner and sequencer of the HI/LO register pair.
// MULT/MULTU/DIV/DIVU run as a WIDTH-iteration shift-add multiply or
// restoring divide on operand magnitudes. Sign correction happens in FIX,
// and HI/LO are committed together on the FIX->IDLE edge.
// MTHI/MTLO write HI/LO directly from IDLE without stalling.
// Optional build macro: MULDIV_FAST_MUL_EN. When it is defined, MULT/MULTU use
// a single-cycle full-width multiply and go from IDLE straight to FIX.
module muldiv_sched #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [2:0] OP_MTHI = 3'b100;
    localparam logic [2:0] OP_MTLO = 3'b101;

    localparam int            CW        = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX,
        S_ZDIV
    } state_t;

    state_t               state_reg;
    logic [2*WIDTH-1:0]   acc_reg;      // mul: {partial product, multiplier}; div: {remainder, dividend/quotient}
    logic [WIDTH-1:0]     opb_reg;      // multiplicand or divisor magnitude
    logic [CW-1:0]        cnt_reg;
    logic                 is_div_reg;
    logic                 neg_q_reg;    // operand signs differ: negate product / quotient
    logic                 neg_r_reg;    // dividend negative: negate remainder
    logic [WIDTH-1:0]     hi_reg;
    logic [WIDTH-1:0]     lo_reg;
    logic                 busy_reg;
    logic                 done_reg;
    logic                 dbz_reg;

    // Operand decode and magnitude extraction for the issuing op.
    // Codes 000..011 (op[2] low) are the mul/div group. op[1] selects divide,
    // and op[0] low selects the signed variant.
    logic                 is_muldiv_op;
    logic                 op_is_div;
    logic                 op_signed;
    logic                 a_neg;
    logic                 b_neg;
    logic [WIDTH-1:0]     mag_a;
    logic [WIDTH-1:0]     mag_b;

    assign is_muldiv_op = ~op[2];
    assign op_is_div    = op[1];
    assign op_signed    = ~op[0];
    assign a_neg        = op_signed & src_a[WIDTH-1];
    assign b_neg        = op_signed & src_b[WIDTH-1];
    assign mag_a        = a_neg ? -src_a : src_a;
    assign mag_b        = b_neg ? -src_b : src_b;

    // The stall request is raised combinationally in the issue cycle, so the
    // pipeline holds before the FSM has left IDLE.
    assign stall = (state_reg != S_IDLE) | (start & is_muldiv_op & ~flush);

    // Shift-add multiply step: add the multiplicand into the upper half when
    // the current multiplier bit is set, then shift the whole pair right.
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_step;

    assign mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]}
                    + (acc_reg[0] ? {1'b0, opb_reg} : {(WIDTH+1){1'b0}});
    assign mul_step = {mul_sum, acc_reg[WIDTH-1:1]};

    // Restoring divide step: shift the next dividend bit into the remainder,
    // then trial-subtract the divisor. The borrow bit decides the quotient bit
    // and whether the remainder is restored.
    logic [WIDTH:0]       div_shift;
    logic [WIDTH:0]       div_trial;
    logic                 div_borrow;
    logic [2*WIDTH-1:0]   div_step;

    assign div_shift  = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
    assign div_trial  = div_shift - {1'b0, opb_reg};
    assign div_borrow = div_trial[WIDTH];
    assign div_step   = {(div_borrow ? div_shift[WIDTH-1:0] : div_trial[WIDTH-1:0]),
                         acc_reg[WIDTH-2:0], ~div_borrow};

    // Sign correction applied to the magnitude result during FIX.
    // Negating 0x80..0 wraps to itself, which gives the overflow-quotient behaviour.
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quot_fix;
    logic [WIDTH-1:0]     rem_fix;

    assign prod_fix = neg_q_reg ? -acc_reg : acc_reg;
    assign quot_fix = neg_q_reg ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
    assign rem_fix  = neg_r_reg ? -acc_reg[2*WIDTH-1:WIDTH] : acc_reg[2*WIDTH-1:WIDTH];

`ifdef MULDIV_FAST_MUL_EN
    logic [2*WIDTH-1:0]   fast_prod;
    assign fast_prod = {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
`endif

    // Sequencer FSM with registered busy/done/div_by_zero and the HI/LO registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg  <= S_IDLE;
            acc_reg    <= '0;
            opb_reg    <= '0;
            cnt_reg    <= '0;
            is_div_reg <= 1'b0;
            neg_q_reg  <= 1'b0;
            neg_r_reg  <= 1'b0;
            hi_reg     <= '0;
            lo_reg     <= '0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            dbz_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            dbz_reg  <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (start && !flush) begin
                        if (is_muldiv_op) begin
                            acc_reg    <= {{WIDTH{1'b0}}, mag_a};
                            opb_reg    <= mag_b;
                            cnt_reg    <= '0;
                            is_div_reg <= op_is_div;
                            neg_q_reg  <= a_neg ^ b_neg;
                            neg_r_reg  <= a_neg;
                            busy_reg   <= 1'b1;
                            if (op_is_div && (src_b == '0)) begin
                                state_reg <= S_ZDIV;
                            end else begin
`ifdef MULDIV_FAST_MUL_EN
                                if (!op_is_div) begin
                                    acc_reg   <= fast_prod;
                                    state_reg <= S_FIX;
                                end else begin
                                    state_reg <= S_RUN;
                                end
`else
                                state_reg <= S_RUN;
`endif
                            end
                        end else if (op == OP_MTHI) begin
                            hi_reg <= src_a;
                        end else if (op == OP_MTLO) begin
                            lo_reg <= src_a;
                        end
                    end
                end
                S_RUN: begin
                    if (flush) begin
                        state_reg <= S_IDLE;
                        busy_reg  <= 1'b0;
                    end else begin
                        acc_reg <= is_div_reg ? div_step : mul_step;
                        cnt_reg <= cnt_reg + CW'(1);
                        if (cnt_reg == LAST_ITER) begin
                            state_reg <= S_FIX;
                        end
                    end
                end
                S_FIX: begin
                    state_reg <= S_IDLE;
                    busy_reg  <= 1'b0;
                    if (!flush) begin
                        if (is_div_reg) begin
                            hi_reg <= rem_fix;
                            lo_reg <= quot_fix;
                        end else begin
                            hi_reg <= prod_fix[2*WIDTH-1:WIDTH];
                            lo_reg <= prod_fix[WIDTH-1:0];
                        end
                        done_reg <= 1'b1;
                    end
                end
                S_ZDIV: begin
                    state_reg <= S_IDLE;
                    busy_reg  <= 1'b0;
                    if (!flush) begin
                        done_reg <= 1'b1;
                        dbz_reg  <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = busy_reg;
    assign done        = done_reg;
    assign div_by_zero = dbz_reg;
    assign hi          = hi_reg;
    assign lo          = lo_reg;

endmodule

// File: tb/tb_muldiv_sched.sv
// Bench for muldiv_sched. Uses directed cases and random ops, and compares
// results with an arithmetic reference model of HI/LO.
module tb_muldiv_sched;

    logic        clk;
    logic        resetn;
    logic        start;
    logic [2:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        stall;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] ref_hi = 32'h0;
    logic [31:0] ref_lo = 32'h0;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_STALL = 2;
`else
    localparam int MUL_STALL = 34;
`endif

    muldiv_sched #(.WIDTH(32)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .start       (start),
        .op          (op),
        .src_a       (src_a),
        .src_b       (src_b),
        .flush       (flush),
        .stall       (stall),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model of HI/LO, computed with plain 64-bit / signed arithmetic.
    function automatic bit model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint      sp;
        logic [63:0] up;
        int          sa;
        int          sb;
        bit          z;
        z = 1'b0;
        sa = $signed(a);
        sb = $signed(b);
        case (o)
            3'b000: begin
                sp = longint'(sa) * longint'(sb);
                up = sp;
                ref_hi = up[63:32];
                ref_lo = up[31:0];
            end
            3'b001: begin
                up = {32'h0, a} * {32'h0, b};
                ref_hi = up[63:32];
                ref_lo = up[31:0];
            end
            3'b010: begin
                if (b == 32'h0) z = 1'b1;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    ref_lo = 32'h8000_0000;
                    ref_hi = 32'h0;
                end else begin
                    ref_lo = sa / sb;
                    ref_hi = sa % sb;
                end
            end
            3'b011: begin
                if (b == 32'h0) z = 1'b1;
                else begin
                    ref_lo = a / b;
                    ref_hi = a % b;
                end
            end
            3'b100: ref_hi = a;
            3'b101: ref_lo = a;
            default: ;
        endcase
        return z;
    endfunction

    // Issue a MUL/DIV op; measure the stall length, then check done/dbz and HI/LO.
    task automatic do_muldiv(input string tag, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        bit z;
        int n;
        int exp_n;
        z = model(o, a, b);
        exp_n = z ? 2 : (o[1] ? 34 : MUL_STALL);
        @(negedge clk);
        start = 1'b1; op = o; src_a = a; src_b = b; flush = 1'b0;
        #1;
        n = 0;
        while (stall === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
            start = 1'b0;
            #1;
            if (n == 1) chk({tag, "_busy"}, {63'h0, busy}, 64'h1);
        end
        start = 1'b0;
        $display("op=%0d a=%h b=%h stall=%0d hi=%h lo=%h done=%b dbz=%b",
                 o, a, b, n, hi, lo, done, div_by_zero);
        chk({tag, "_stall_len"}, 64'(n), 64'(exp_n));
        chk({tag, "_done"}, {63'h0, done}, 64'h1);
        chk({tag, "_dbz"}, {63'h0, div_by_zero}, {63'h0, z});
        chk({tag, "_hi"}, {32'h0, hi}, {32'h0, ref_hi});
        chk({tag, "_lo"}, {32'h0, lo}, {32'h0, ref_lo});
        @(negedge clk);
        #1;
        chk({tag, "_done_pulse"}, {63'h0, done}, 64'h0);
    endtask

    // Issue MTHI/MTLO; it must not stall and must update the register at the next edge.
    task automatic do_mt(input string tag, input logic [2:0] o, input logic [31:0] a);
        bit z;
        z = model(o, a, 32'h0);
        @(negedge clk);
        start = 1'b1; op = o; src_a = a; src_b = $urandom; flush = 1'b0;
        #1;
        chk({tag, "_stall"}, {63'h0, stall}, {63'h0, z});
        @(negedge clk);
        start = 1'b0;
        #1;
        $display("op=%0d a=%h hi=%h lo=%h", o, a, hi, lo);
        chk({tag, "_hi"}, {32'h0, hi}, {32'h0, ref_hi});
        chk({tag, "_lo"}, {32'h0, lo}, {32'h0, ref_lo});
        chk({tag, "_nodone"}, {63'h0, done}, 64'h0);
    endtask

    initial begin
        logic [2:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        resetn = 1'b0; start = 1'b0; op = 3'b000; src_a = 32'h0; src_b = 32'h0; flush = 1'b0;
        #1;
        chk("reset_busy", {63'h0, busy}, 64'h0);
        chk("reset_done", {63'h0, done}, 64'h0);
        chk("reset_hilo", {hi, lo}, 64'h0);
        chk("reset_stall", {63'h0, stall}, 64'h0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;

        // Directed arithmetic cases
        do_muldiv("multu_max", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        do_muldiv("mult_neg", 3'b000, 32'hFFFF_FFFD, 32'd5);
        do_muldiv("divu_7_2", 3'b011, 32'd7, 32'd2);
        do_muldiv("div_m7_2", 3'b010, 32'hFFFF_FFF9, 32'd2);
        do_muldiv("div_ovf", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF);

        // Divide by zero leaves HI/LO untouched
        do_mt("mthi_11", 3'b100, 32'h11);
        do_mt("mtlo_22", 3'b101, 32'h22);
        do_muldiv("div_zero", 3'b010, 32'd5, 32'd0);

        // Flush at RUN cycle 10 cancels the multiply
        @(negedge clk);
        start = 1'b1; op = 3'b000; src_a = 32'h1234_5678; src_b = 32'h9ABC_DEF0;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        #1;
        chk("flush_stall_before", {63'h0, stall}, 64'h1);
        @(negedge clk);
        flush = 1'b0;
        #1;
        $display("flush: busy=%b stall=%b done=%b hi=%h lo=%h", busy, stall, done, hi, lo);
        chk("flush_busy", {63'h0, busy}, 64'h0);
        chk("flush_stall", {63'h0, stall}, 64'h0);
        chk("flush_done", {63'h0, done}, 64'h0);
        chk("flush_hilo", {hi, lo}, {ref_hi, ref_lo});
        @(negedge clk);
        #1;
        chk("flush_done_late", {63'h0, done}, 64'h0);
        do_mt("mthi_1234", 3'b100, 32'h1234);

        // A start that arrives together with flush is ignored
        @(negedge clk);
        start = 1'b1; flush = 1'b1; op = 3'b011; src_a = 32'd9; src_b = 32'd4;
        #1;
        chk("sflush_stall", {63'h0, stall}, 64'h0);
        @(negedge clk);
        op = 3'b101; src_a = 32'hDEAD_BEEF;
        #1;
        chk("sflush_busy", {63'h0, busy}, 64'h0);
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        #1;
        $display("start+flush: busy=%b hi=%h lo=%h", busy, hi, lo);
        chk("sflush_hilo", {hi, lo}, {ref_hi, ref_lo});

        // Random ops against the model
        for (int i = 0; i < 16; i++) begin
            ro = 3'($urandom_range(0, 5));
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 7) == 0) rb = 32'h0;
            if ($urandom_range(0, 7) == 0) begin
                ra = 32'h8000_0000;
                rb = 32'hFFFF_FFFF;
            end
            if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(1, 31);
            if (ro[2]) do_mt("rand_mt", ro, ra);
            else do_muldiv("rand_md", ro, ra, rb);
        end

        // Asynchronous reset in the middle of an operation
        do_mt("mtlo_abcd", 3'b101, 32'hABCD);
        @(negedge clk);
        start = 1'b1; op = 3'b001; src_a = 32'h7; src_b = 32'h9;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2;
        resetn = 1'b0;
        #1;
        ref_hi = 32'h0;
        ref_lo = 32'h0;
        $display("async reset: busy=%b stall=%b hi=%h lo=%h", busy, stall, hi, lo);
        chk("arst_busy", {63'h0, busy}, 64'h0);
        chk("arst_stall", {63'h0, stall}, 64'h0);
        chk("arst_hilo", {hi, lo}, 64'h0);
        @(negedge clk);
        resetn = 1'b1;
        do_muldiv("multu_after_rst", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
